// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between the fetch stage (I)
// and the memory-access stage (D). One bus transaction at a time through
// IDLE -> REQ -> RESP, with stall reporting to the hazard logic and
// flush-based cancellation of an in-flight fetch.
// Optional build macro: ARB_FAIR_EN (alternating grant when both stages request).
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] iRdata,
    output logic              iValid,
    input  logic              flushI,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [3:0]        dBe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic [DATA_W-1:0] dRdata,
    output logic              dValid,
    output logic              busReq,
    output logic              busWe,
    output logic [3:0]        busBe,
    output logic [ADDR_W-1:0] busAddr,
    output logic [DATA_W-1:0] busWdata,
    input  logic              busGnt,
    input  logic              busRvalid,
    input  logic [DATA_W-1:0] busRdata,
    output logic              stallF,
    output logic              stallM
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_owner_q, last_owner_d;
    logic                drop_q, drop_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [3:0]          bus_be_q, bus_be_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

    logic                i_live;
    logic                pick_d;

    // Grant selection: a flushed fetch never competes for the bus.
    always_comb begin
        i_live = iReq & ~flushI;
`ifdef ARB_FAIR_EN
        pick_d = dReq & (~i_live | (last_owner_q == OWN_I));
`else
        pick_d = dReq;
`endif
    end

    // Next-state logic for the FSM, ownership, drop flag and bus command.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        drop_d       = drop_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick_d) begin
                    owner_d     = OWN_D;
                    bus_we_d    = dWe;
                    bus_be_d    = dBe;
                    bus_addr_d  = dAddr;
                    bus_wdata_d = dWdata;
                    drop_d      = 1'b0;
                    bus_req_d   = 1'b1;
                    state_d     = S_REQ;
                end else if (i_live) begin
                    owner_d     = OWN_I;
                    bus_we_d    = 1'b0;
                    bus_be_d    = 4'hF;
                    bus_addr_d  = iAddr;
                    bus_wdata_d = '0;
                    drop_d      = 1'b0;
                    bus_req_d   = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (flushI && owner_q == OWN_I) begin
                    drop_d = 1'b1;
                end
                if (busGnt) begin
                    bus_req_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                // Leaving RESP clears drop even if a flush arrives in the same cycle.
                if (busRvalid) begin
                    last_owner_d = owner_q;
                    drop_d       = 1'b0;
                    state_d      = S_IDLE;
                end else if (flushI && owner_q == OWN_I) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and bus command registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_D;
            last_owner_q <= OWN_I;
            drop_q       <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_be_q     <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            drop_q       <= drop_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    // Response delivery and stall reporting, combinational in the response cycle.
    always_comb begin
        iRdata   = busRdata;
        dRdata   = busRdata;
        iValid   = busRvalid & (owner_q == OWN_I) & (state_q == S_RESP) & ~drop_q & ~flushI;
        dValid   = busRvalid & (owner_q == OWN_D) & (state_q == S_RESP);
        stallF   = iReq & ~iValid & ~flushI;
        stallM   = dReq & ~dValid;
        busReq   = bus_req_q;
        busWe    = bus_we_q;
        busBe    = bus_be_q;
        busAddr  = bus_addr_q;
        busWdata = bus_wdata_q;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single external memory port between the instruction-fetch stage (I) and the memory-access stage (D) of the 5-stage pipeline. It drives one request/grant/response bus transaction at a time and reports busy requesters to the hazard logic as `stallF` and `stallM`. A taken-branch flush cancels delivery of an in-flight fetch.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Must be 32; byte enables are 4 bits.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rstN`  in  1  reset, synchronous, active-low.
- `iReq`  in  1  fetch request; held with `iAddr` stable until `iValid` or `flushI`.
- `iAddr`  in  ADDR_W  fetch address.
- `iRdata`  out  DATA_W  fetched word; meaningful only when `iValid`=1.
- `iValid`  out  1  one-cycle fetch completion pulse.
- `flushI`  in  1  discard the current fetch (wrong branch).
- `dReq`  in  1  data request; `dAddr`/`dWe`/`dBe`/`dWdata` held until `dValid`.
- `dWe`  in  1  1 = store, 0 = load.
- `dBe`  in  4  store byte enables.
- `dAddr`  in  ADDR_W  data address.
- `dWdata`  in  DATA_W  store data.
- `dRdata`  out  DATA_W  load data; meaningful only when `dValid`=1.
- `dValid`  out  1  one-cycle data completion pulse (loads and stores).
- `busReq`  out  1  bus request; held until `busGnt`.
- `busWe`, `busBe`, `busAddr`, `busWdata`  out  1/4/ADDR_W/DATA_W  registered command fields.
- `busGnt`  in  1  bus accepts the command this cycle.
- `busRvalid`  in  1  one response per accepted command, loads and stores; arrives ≥1 cycle after `busGnt`.
- `busRdata`  in  DATA_W  response data.
- `stallF`  out  1  to hazard logic: `iReq & ~iValid & ~flushI`.
- `stallM`  out  1  to hazard logic: `dReq & ~dValid`.

## Operation
- FSM states: IDLE, REQ, RESP. Registers: `owner` (I/D), `drop`, `lastOwner`, and the bus command registers.
- IDLE:
  - If `dReq`=1, set `owner`=D and latch the D command. Otherwise, if `iReq & ~flushI`, set `owner`=I and latch `iAddr` with `busWe`=0 and `busBe`=4'hF.
  - On either grant, go to REQ. If neither requester is active, stay in IDLE.
- REQ: `busReq`=1. On `busGnt`, go to RESP. `busReq` is never withdrawn before `busGnt`.
- RESP: `busReq`=0. On `busRvalid`, go to IDLE and update `lastOwner`=`owner`.
- Response delivery (combinational in the `busRvalid` cycle):
  - `iRdata` and `dRdata` are driven directly from `busRdata`.
  - `iValid` = `busRvalid & owner==I & state==RESP & ~drop & ~flushI`.
  - `dValid` = `busRvalid & owner==D & state==RESP`.
- Flush handling: `flushI` while `owner`=I in REQ or RESP sets `drop`. The transaction still completes on the bus, its response is discarded, and `drop` is cleared on leaving RESP. `flushI` has no effect on a D transaction.
- A `busRvalid` seen in IDLE or REQ is ignored.
- There is always one IDLE cycle between transactions, so a requester whose request just completed is never re-served on a stale request.
- Reset (`rstN`=0 at an edge): state=IDLE, `owner`=D, `drop`=0, `lastOwner`=I, all bus command registers 0. The bus is reset in the same cycle, so no response is expected afterwards.

## Timing
- Reset values of outputs: `busReq`=0, `busWe`=0, `busBe`=0, `busAddr`=0, `busWdata`=0. `iValid`, `dValid`, `stallF` and `stallM` are 0 whenever their request input is 0.
- Minimum latency, request to valid:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: `busReq`, with `busGnt` in the same cycle.
  - Cycle 2: `busRvalid` and the valid pulse.
  - Each additional cycle of grant or response wait adds one cycle.
- Back-to-back throughput: one transaction per 3 cycles minimum.
- Simultaneous `iReq` and `dReq` in IDLE: D wins (default build). I waits with `stallF`=1.

## Configuration
- `ARB_FAIR_EN` defined: when both requesters are active in IDLE, the grant goes to the requester that is not `lastOwner` (alternation). A single active requester is always granted.
- `ARB_FAIR_EN` undefined: fixed priority, D over I. `lastOwner` is still maintained but has no effect.

## Test plan
- Reset with `iReq`=1 and `iAddr`=0x100; release reset; `busGnt`=1 immediately and `busRvalid` one cycle later with `busRdata`=0xDEADBEEF → `busAddr`=0x100, `busBe`=4'hF, `iValid` pulse carrying 0xDEADBEEF, `stallF`=1 on every prior request cycle.
- `iReq` and `dReq` asserted in the same cycle, load at 0x200, default build → D is served first and `dValid` pulses. I is then served after one IDLE cycle. `stallF` stays high until `iValid`.
- Same stimulus with `ARB_FAIR_EN` and `lastOwner`=D → I is served first, then D.
- Store with `dBe`=4'b0011 and `dWdata`=0x1234 at 0x300; `busGnt` delayed 3 cycles → `busWe`=1, `busReq` held for 4 cycles, `dValid` pulses on `busRvalid`.
- Fetch in RESP with `flushI` pulsed 1 cycle before `busRvalid` → no `iValid`, FSM returns to IDLE, and the next fetch to 0x400 completes normally.
- `rstN` driven low while in REQ → the next cycle shows state IDLE and `busReq`=0, and no valid pulse ever issues for the aborted request.
